// File: rtl/alu_issue_if.sv
// alu_issue_if: bundles the decoder command channel, the ALU drive/return
// signals, the external register-file load port and the writeback status.
// The slave modport is the issue unit; the master modport is its environment.
interface alu_issue_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
);
  // Command channel from the decoder
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_op;
  logic [REG_ADDR_WIDTH-1:0] cmd_rd;
  logic [REG_ADDR_WIDTH-1:0] cmd_rs0;
  logic [REG_ADDR_WIDTH-1:0] cmd_rs1;
  logic                      cmd_use_imm;
  logic [DATA_WIDTH-1:0]     cmd_imm;

  // ALU drive and result
  logic [2:0]                alu_ctrl;
  logic [DATA_WIDTH-1:0]     alu_in0;
  logic [DATA_WIDTH-1:0]     alu_in1;
  logic [DATA_WIDTH-1:0]     alu_out;

  // External register-file load port
  logic                      ext_wr_en;
  logic [REG_ADDR_WIDTH-1:0] ext_wr_addr;
  logic [DATA_WIDTH-1:0]     ext_wr_data;

  // Writeback status
  logic                      result_valid;
  logic [REG_ADDR_WIDTH-1:0] result_addr;
  logic [DATA_WIDTH-1:0]     result_data;
  logic                      err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs0, cmd_rs1, cmd_use_imm, cmd_imm,
    input  alu_out,
    input  ext_wr_en, ext_wr_addr, ext_wr_data,
    output cmd_ready,
    output alu_ctrl, alu_in0, alu_in1,
    output result_valid, result_addr, result_data, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs0, cmd_rs1, cmd_use_imm, cmd_imm,
    output alu_out,
    output ext_wr_en, ext_wr_addr, ext_wr_data,
    input  cmd_ready,
    input  alu_ctrl, alu_in0, alu_in1,
    input  result_valid, result_addr, result_data, err
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: command-side driver for the 2-operand ALU. Owns the register
// file, issues one command every two cycles (ISSUE then WB) and writes the
// ALU result back at the end of WB.
// Optional feature macro: ALU_ISSUE_R0_ZERO_EN -- when defined, register 0
// is hard-wired to zero (reads 0, writebacks and external writes dropped,
// result_valid/result_data still reported for rd=0).
module alu_issue #(
  parameter int DATA_WIDTH     = 32,
  parameter int NREGS          = 16,
  parameter int REG_ADDR_WIDTH = 4
) (
  input logic        clk,
  input logic        reset,
  alu_issue_if.slave bus
);

  localparam logic [2:0] OP_ILLEGAL = 3'd7;

`ifdef ALU_ISSUE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WB
  } state_t;

  state_t                    state_reg;
  logic [2:0]                op_reg;
  logic [REG_ADDR_WIDTH-1:0] rd_reg;
  logic [REG_ADDR_WIDTH-1:0] rs0_reg;
  logic [REG_ADDR_WIDTH-1:0] rs1_reg;
  logic                      use_imm_reg;
  logic [DATA_WIDTH-1:0]     imm_reg;
  logic [2:0]                ctrl_reg;
  logic                      result_valid_reg;
  logic [REG_ADDR_WIDTH-1:0] result_addr_reg;
  logic [DATA_WIDTH-1:0]     result_data_reg;
  logic                      err_reg;

  logic                      cmd_fire;
  logic                      wb_write;
  logic [DATA_WIDTH-1:0]     regs [NREGS];
  logic [DATA_WIDTH-1:0]     rs0_data;
  logic [DATA_WIDTH-1:0]     rs1_data;

  // Ready in IDLE and WB; forced low while reset is asserted so nothing is
  // accepted during reset, and high again as soon as it is released.
  assign bus.cmd_ready = ~reset & ((state_reg == IDLE) | (state_reg == WB));
  assign cmd_fire      = bus.cmd_valid & bus.cmd_ready;

  // Only legal ops write back; opcode 7 just raises err.
  assign wb_write = (state_reg == WB) && (op_reg != OP_ILLEGAL);

  // Register file: one flop bank per register. Writeback beats a
  // same-address external write; different addresses both land.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (R0_ZERO && gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_ff
        logic [DATA_WIDTH-1:0] value;
        // Register update: reset clear, then writeback, then external load.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            value <= '0;
          end else if (wb_write && rd_reg == REG_ADDR_WIDTH'(gi)) begin
            value <= bus.alu_out;
          end else if (bus.ext_wr_en && bus.ext_wr_addr == REG_ADDR_WIDTH'(gi)) begin
            value <= bus.ext_wr_data;
          end
        end
        assign regs[gi] = value;
      end
    end
  endgenerate

  // Combinational operand read. A command accepted in WB is in ISSUE one
  // cycle later, so it already sees the value written at that edge.
  assign rs0_data = regs[rs0_reg];
  assign rs1_data = use_imm_reg ? imm_reg : regs[rs1_reg];

  // Operands are only presented during ISSUE; the ALU captures them at the
  // end of that cycle.
  assign bus.alu_in0 = (state_reg == ISSUE) ? rs0_data : '0;
  assign bus.alu_in1 = (state_reg == ISSUE) ? rs1_data : '0;

  assign bus.alu_ctrl     = ctrl_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.result_addr  = result_addr_reg;
  assign bus.result_data  = result_data_reg;
  assign bus.err          = err_reg;

  // Issue FSM: latches commands, sequences ISSUE/WB, holds ALU ctrl across
  // both cycles and registers the writeback status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      op_reg           <= '0;
      rd_reg           <= '0;
      rs0_reg          <= '0;
      rs1_reg          <= '0;
      use_imm_reg      <= 1'b0;
      imm_reg          <= '0;
      ctrl_reg         <= '0;
      result_valid_reg <= 1'b0;
      result_addr_reg  <= '0;
      result_data_reg  <= '0;
      err_reg          <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_fire) begin
            op_reg      <= bus.cmd_op;
            rd_reg      <= bus.cmd_rd;
            rs0_reg     <= bus.cmd_rs0;
            rs1_reg     <= bus.cmd_rs1;
            use_imm_reg <= bus.cmd_use_imm;
            imm_reg     <= bus.cmd_imm;
            ctrl_reg    <= bus.cmd_op;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          state_reg <= WB;
        end
        WB: begin
          if (op_reg == OP_ILLEGAL) begin
            err_reg <= 1'b1;
          end else begin
            result_valid_reg <= 1'b1;
            result_addr_reg  <= rd_reg;
            result_data_reg  <= bus.alu_out;
          end
          if (cmd_fire) begin
            op_reg      <= bus.cmd_op;
            rd_reg      <= bus.cmd_rd;
            rs0_reg     <= bus.cmd_rs0;
            rs1_reg     <= bus.cmd_rs1;
            use_imm_reg <= bus.cmd_use_imm;
            imm_reg     <= bus.cmd_imm;
            ctrl_reg    <= bus.cmd_op;
            state_reg   <= ISSUE;
          end else begin
            ctrl_reg  <= '0;
            state_reg <= IDLE;
          end
        end
        default: begin
          ctrl_reg  <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed plan scenarios plus randomized commands for
// alu_issue, with a behavioural ALU, a register-file reference model and a
// result scoreboard drained by an independent monitor.
module tb_alu_issue;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  alu_issue_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

  alu_issue #(.DATA_WIDTH(DW), .NREGS(NR), .REG_ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ALU semantics: 0/6 pass in0, 1 add, 2 sub, 3 eq, 4 signed le, 5 signed ge.
  function automatic logic [DW-1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return (a == b) ? 32'd1 : 32'd0;
      3'd4:    return ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      3'd5:    return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      3'd7:    return '0;
      default: return a;
    endcase
  endfunction

  // Behavioural ALU: registered inputs, combinational output.
  logic [2:0]    alu_ctrl_q;
  logic [DW-1:0] alu_a_q, alu_b_q;
  always @(posedge clk) begin
    alu_ctrl_q <= bus.alu_ctrl;
    alu_a_q    <= bus.alu_in0;
    alu_b_q    <= bus.alu_in1;
  end
  assign bus.alu_out = alu_fn(alu_ctrl_q, alu_a_q, alu_b_q);

  // Reference register file and error flag.
  logic [DW-1:0] model_regs [NR];
  bit            err_m = 1'b0;

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (a == 0) return '0;
`endif
    return model_regs[a];
  endfunction

  task automatic mwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (a == 0) return;
`endif
    model_regs[a] = d;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every result pulse pops one expectation and checks address,
  // data and the cycle it appeared on.
  always @(negedge clk) begin
    if (!reset && bus.result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=addr %0d data 0x%08h required=no result", bus.result_addr, bus.result_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_addr", 32'(bus.result_addr), 32'(mon_e.addr));
        chk("result_data", bus.result_data, mon_e.data);
        chk("result_cycle", 32'(cyc), 32'(mon_e.due));
        $display("result addr=%0d data=0x%08h cycle=%0d", bus.result_addr, bus.result_data, cyc);
      end
      last_addr = bus.result_addr;
      last_data = bus.result_data;
    end
  end

  // Issue one command (called at a negedge); pushes the expected result.
  task automatic send(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs0,
                      input logic [AW-1:0] rs1, input logic ui, input logic [DW-1:0] imm, output int acc);
    logic [DW-1:0] a, b, r;
    int n;
    exp_t e;
    bus.cmd_valid = 1'b1;  bus.cmd_op = op;  bus.cmd_rd = rd;
    bus.cmd_rs0 = rs0;  bus.cmd_rs1 = rs1;  bus.cmd_use_imm = ui;  bus.cmd_imm = imm;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout actual=not ready required=ready within 20 cycles");
      bus.cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    a = mread(rs0);
    b = ui ? imm : mread(rs1);
    if (op == 3'd7) begin
      err_m = 1'b1;
    end else begin
      r = alu_fn(op, a, b);
      e.addr = rd;  e.data = r;  e.due = acc + 2;
      exp_q.push_back(e);
      mwrite(rd, r);
    end
    $display("cmd op=%0d rd=%0d rs0=%0d rs1=%0d imm=%0d/0x%08h accept=%0d", op, rd, rs0, rs1, ui, imm, acc);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
  endtask

  task automatic ext_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ext_wr_en = 1'b1;  bus.ext_wr_addr = a;  bus.ext_wr_data = d;
    @(posedge clk);
    @(negedge clk);
    bus.ext_wr_en = 1'b0;
    mwrite(a, d);
    $display("ext r%0d=0x%08h", a, d);
  endtask

  task automatic readback(input logic [AW-1:0] r);
    int acc;
    send(3'd0, r, r, '0, 1'b0, '0, acc);
    drain();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    chk({tag, "_alu_ctrl"}, 32'(bus.alu_ctrl), 32'd0);
    chk({tag, "_alu_in0"}, bus.alu_in0, 32'd0);
    chk({tag, "_alu_in1"}, bus.alu_in1, 32'd0);
    chk({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
    chk({tag, "_result_addr"}, 32'(bus.result_addr), 32'd0);
    chk({tag, "_result_data"}, bus.result_data, 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1, a2;
    bus.cmd_valid = 1'b0;  bus.cmd_op = '0;  bus.cmd_rd = '0;  bus.cmd_rs0 = '0;
    bus.cmd_rs1 = '0;  bus.cmd_use_imm = 1'b0;  bus.cmd_imm = '0;
    bus.ext_wr_en = 1'b0;  bus.ext_wr_addr = '0;  bus.ext_wr_data = '0;
    for (int i = 0; i < NR; i++) model_regs[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    #1 chk("ready_after_release", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);

    // Add and result timing
    ext_write(4'd1, 32'd5);
    ext_write(4'd2, 32'd7);
    send(3'd1, 4'd3, 4'd1, 4'd2, 1'b0, '0, a1);
    drain();
    chk("add_data", last_data, 32'd12);
    chk("add_addr", 32'(last_addr), 32'd3);
    chk("idle_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    chk("idle_alu_in0", bus.alu_in0, 32'd0);
    chk("idle_alu_in1", bus.alu_in1, 32'd0);
    readback(4'd3);
    chk("add_r3_read", last_data, 32'd12);

    // Sub followed back-to-back by a dependent immediate add
    send(3'd2, 4'd4, 4'd1, 4'd2, 1'b0, '0, a1);
    send(3'd1, 4'd5, 4'd4, 4'd0, 1'b1, 32'd2, a2);
    chk("b2b_interval", 32'(a2 - a1), 32'd2);
    drain();
    readback(4'd4);
    chk("sub_r4", last_data, 32'hFFFF_FFFE);
    readback(4'd5);
    chk("dep_r5", last_data, 32'd0);

    // Signed compares
    ext_write(4'd1, 32'h8000_0000);
    ext_write(4'd2, 32'd1);
    send(3'd4, 4'd6, 4'd1, 4'd2, 1'b0, '0, a1);
    drain();
    chk("le_signed", last_data, 32'd1);
    send(3'd5, 4'd6, 4'd1, 4'd2, 1'b0, '0, a1);
    drain();
    chk("ge_signed", last_data, 32'd0);
    ext_write(4'd2, 32'h8000_0000);
    send(3'd3, 4'd6, 4'd1, 4'd2, 1'b0, '0, a1);
    drain();
    chk("eq_equal", last_data, 32'd1);

    // Illegal opcode
    chk("err_clear_before", 32'(bus.err), 32'd0);
    send(3'd7, 4'd6, 4'd1, 4'd2, 1'b0, '0, a1);
    @(negedge clk);
    chk("err_during_wb", 32'(bus.err), 32'd0);
    @(negedge clk);
    chk("err_after_wb", 32'(bus.err), 32'd1);
    @(negedge clk);
    readback(4'd6);
    chk("illegal_r6_kept", last_data, 32'd1);
    send(3'd1, 4'd8, 4'd1, 4'd0, 1'b1, 32'd1, a1);
    drain();
    chk("after_illegal_add", last_data, 32'h8000_0001);
    chk("err_sticky", 32'(bus.err), 32'd1);

    // Writeback/external-write collision, same and different address
    ext_write(4'd1, 32'd5);
    ext_write(4'd2, 32'd7);
    send(3'd1, 4'd3, 4'd1, 4'd2, 1'b0, '0, a1);
    @(negedge clk);
    bus.ext_wr_en = 1'b1;  bus.ext_wr_addr = 4'd3;  bus.ext_wr_data = 32'hDEAD;
    @(posedge clk);
    @(negedge clk);
    bus.ext_wr_en = 1'b0;
    drain();
    readback(4'd3);
    chk("collide_same_r3", last_data, 32'd12);
    send(3'd2, 4'd3, 4'd2, 4'd1, 1'b0, '0, a1);
    @(negedge clk);
    bus.ext_wr_en = 1'b1;  bus.ext_wr_addr = 4'd7;  bus.ext_wr_data = 32'hDEAD;
    @(posedge clk);
    @(negedge clk);
    bus.ext_wr_en = 1'b0;
    mwrite(4'd7, 32'hDEAD);
    drain();
    readback(4'd3);
    chk("collide_diff_r3", last_data, 32'd2);
    readback(4'd7);
    chk("collide_diff_r7", last_data, 32'hDEAD);

    // Reset during WB of an add
    send(3'd1, 4'd3, 4'd1, 4'd2, 1'b0, '0, a1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    err_m = 1'b0;
    #1 chk_reset_outputs("midop");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("midop_ready_release", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    readback(4'd3);
    chk("midop_r3_cleared", last_data, 32'd0);

    // Register 0 behaviour
    ext_write(4'd1, 32'd5);
    ext_write(4'd2, 32'd7);
    ext_write(4'd0, 32'd99);
    send(3'd1, 4'd0, 4'd1, 4'd2, 1'b0, '0, a1);
    drain();
    chk("r0_result_data", last_data, 32'd12);
    readback(4'd0);
`ifdef ALU_ISSUE_R0_ZERO_EN
    chk("r0_reads_zero", last_data, 32'd0);
`else
    chk("r0_ordinary", last_data, 32'd12);
`endif

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        drain();
        ext_write(AW'($urandom_range(0, NR - 1)), $urandom);
      end else begin
        send(($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
             AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
             AW'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3)), a1);
      end
    end
    drain();
    for (int r = 0; r < NR; r++) begin
      readback(AW'(r));
    end
    chk("err_final", 32'(bus.err), 32'(err_m));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
